// File: rtl/logic_sweep_checker.sv
// Truth-table sweeper/checker for an N_IN-input combinational gate (AND/OR/NAND/NOR/XOR/XNOR).
// Optional build macro SWEEP_STOP_ON_ERR_EN: end the sweep at the first mismatching vector.

module logic_sweep_checker_gate #(
  parameter int N_IN = 2
) (
  input  logic [2:0]      i_mode,
  input  logic [N_IN-1:0] i_vec,
  output logic            o_y
);
  always_comb begin
    o_y = 1'b0;
    case (i_mode)
      3'd0:    o_y =  (&i_vec);
      3'd1:    o_y =  (|i_vec);
      3'd2:    o_y = ~(&i_vec);
      3'd3:    o_y = ~(|i_vec);
      3'd4:    o_y =  (^i_vec);
      3'd5:    o_y = ~(^i_vec);
      default: o_y = 1'b0;
    endcase
  end
endmodule

module logic_sweep_checker #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [2:0]      i_mode,
  output logic [N_IN-1:0] o_vec_out,
  input  logic            i_dut_y,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_pass,
  output logic [N_IN:0]   o_err_count,
  output logic [N_IN-1:0] o_first_err_vec,
  output logic            o_first_err_valid
);
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state;
  logic [2:0]      r_mode;
  logic [N_IN-1:0] r_vec;
  logic [CW-1:0]   r_cnt;
  logic            r_busy, r_done, r_pass;
  logic [N_IN:0]   r_err;
  logic [N_IN-1:0] r_fev;
  logic            r_fvalid;

  logic            w_exp, w_mis, w_sample, w_last, w_stop, w_legal;
  logic [N_IN:0]   w_err_next;

  logic_sweep_checker_gate #(.N_IN(N_IN)) u_gate (
    .i_mode (r_mode),
    .i_vec  (r_vec),
    .o_y    (w_exp)
  );

  assign w_legal    = (i_mode < 3'd6);
  assign w_sample   = (r_cnt == CW'(SETTLE - 1));
  assign w_mis      = (i_dut_y != w_exp);
  assign w_last     = &r_vec;
  assign w_err_next = r_err + {{N_IN{1'b0}}, w_mis};
`ifdef SWEEP_STOP_ON_ERR_EN
  assign w_stop     = w_last | w_mis;
`else
  assign w_stop     = w_last;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_mode   <= 3'd0;
      r_vec    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_err    <= '0;
      r_fev    <= '0;
      r_fvalid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_err    <= '0;
            r_fev    <= '0;
            r_fvalid <= 1'b0;
            r_pass   <= 1'b0;
            if (w_legal) begin
              r_mode  <= i_mode;
              r_vec   <= '0;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
              r_state <= S_RUN;
            end else begin
              // reserved function: report a failed check without sweeping
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_RUN: begin
          if (w_sample) begin
            r_err <= w_err_next;
            if (w_mis && !r_fvalid) begin
              r_fev    <= r_vec;
              r_fvalid <= 1'b1;
            end
            if (w_stop) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_err_next == '0);
              r_state <= S_DONE;
            end else begin
              r_vec <= r_vec + N_IN'(1);
              r_cnt <= '0;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_vec_out         = r_vec;
  assign o_busy            = r_busy;
  assign o_done            = r_done;
  assign o_pass            = r_pass;
  assign o_err_count       = r_err;
  assign o_first_err_vec   = r_fev;
  assign o_first_err_valid = r_fvalid;
endmodule

// File: tb/tb_logic_sweep_checker.sv
// Bench for logic_sweep_checker: two instances (N_IN=2/SETTLE=1 and N_IN=3/SETTLE=3) driven by a table-based gate model.
module tb_logic_sweep_checker;
  logic       clk, rst, start_a, start_b;
  logic [2:0] mode;
  logic [7:0] tt;
  bit         sel;
  int         n_tests = 0, n_fail = 0;

  logic [1:0] a_vec, a_fev;
  logic [2:0] a_err;
  logic       a_y, a_busy, a_done, a_pass, a_fval;
  logic [2:0] b_vec, b_fev;
  logic [3:0] b_err;
  logic       b_y, b_busy, b_done, b_pass, b_fval;

  logic [2:0] ob_vec, ob_fev;
  logic [3:0] ob_err;
  logic       ob_busy, ob_done, ob_pass, ob_fval;

  assign a_y = tt[a_vec];
  assign b_y = tt[b_vec];

  always_comb begin
    ob_vec  = sel ? b_vec  : {1'b0, a_vec};
    ob_fev  = sel ? b_fev  : {1'b0, a_fev};
    ob_err  = sel ? b_err  : {1'b0, a_err};
    ob_busy = sel ? b_busy : a_busy;
    ob_done = sel ? b_done : a_done;
    ob_pass = sel ? b_pass : a_pass;
    ob_fval = sel ? b_fval : a_fval;
  end

  logic_sweep_checker #(.N_IN(2), .SETTLE(1)) u_a (
    .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_mode(mode), .o_vec_out(a_vec),
    .i_dut_y(a_y), .o_busy(a_busy), .o_done(a_done), .o_pass(a_pass),
    .o_err_count(a_err), .o_first_err_vec(a_fev), .o_first_err_valid(a_fval)
  );

  logic_sweep_checker #(.N_IN(3), .SETTLE(3)) u_b (
    .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_mode(mode), .o_vec_out(b_vec),
    .i_dut_y(b_y), .o_busy(b_busy), .o_done(b_done), .o_pass(b_pass),
    .o_err_count(b_err), .o_first_err_vec(b_fev), .o_first_err_valid(b_fval)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // gate function from its definition: AND true only at all-ones, parity for XOR, etc.
  function automatic logic ref_f(input logic [2:0] m, input int v, input int n);
    int ones = $countones(v);
    int all  = (1 << n) - 1;
    case (m)
      3'd0:    return v == all;
      3'd1:    return v != 0;
      3'd2:    return v != all;
      3'd3:    return v == 0;
      3'd4:    return (ones % 2) == 1;
      default: return (ones % 2) == 0;
    endcase
  endfunction

  task automatic set_start(input int s, input logic v);
    if (s != 0) start_b = v; else start_a = v;
  endtask

  task automatic run_sweep(input int s, input logic [2:0] m, input bit disturb);
    int n = (s != 0) ? 3 : 2;
    int st = (s != 0) ? 3 : 1;
    int nv = 1 << n;
    int exp_err = 0, exp_first = 0, nsw, k;
    bit exp_fv = 0;
    for (int v = 0; v < nv; v++)
      if (tt[v] != ref_f(m, v, n)) begin
        if (!exp_fv) exp_first = v;
        exp_fv = 1;
        exp_err++;
      end
    nsw = nv;
`ifdef SWEEP_STOP_ON_ERR_EN
    if (exp_fv) begin nsw = exp_first + 1; exp_err = 1; end
`endif
    k = nsw * st;
    sel = (s != 0);
    mode = m;
    set_start(s, 1'b1);
    @(posedge clk); #1;
    set_start(s, 1'b0);
    for (int c = 1; c <= k; c++) begin
      n_tests++;
      if ({ob_vec, ob_busy, ob_done} !== {3'((c - 1) / st), 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL run_cycle s=%0d m=%0d c=%0d: vec/busy/done got %0h/%0b/%0b want %0h/1/0",
                 s, m, c, ob_vec, ob_busy, ob_done, (c - 1) / st);
      end
      if (disturb && c == 2) begin set_start(s, 1'b1); mode = 3'd4; end
      if (disturb && c == 3) begin set_start(s, 1'b0); mode = m; end
      @(posedge clk); #1;
    end
    set_start(s, 1'b0);
    mode = m;
    n_tests++;
    if ({ob_done, ob_busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL done_timing s=%0d m=%0d: done/busy got %0b/%0b want 1/0", s, m, ob_done, ob_busy);
    end
    n_tests++;
    if (ob_err !== 4'(exp_err)) begin
      n_fail++;
      $display("FAIL err_count s=%0d m=%0d: got %0d want %0d", s, m, ob_err, exp_err);
    end
    n_tests++;
    if (ob_pass !== (exp_err == 0)) begin
      n_fail++;
      $display("FAIL pass s=%0d m=%0d: got %0b want %0b", s, m, ob_pass, exp_err == 0);
    end
    n_tests++;
    if (ob_fval !== exp_fv || (exp_fv && ob_fev !== 3'(exp_first))) begin
      n_fail++;
      $display("FAIL first_err s=%0d m=%0d: valid/vec got %0b/%0d want %0b/%0d",
               s, m, ob_fval, ob_fev, exp_fv, exp_first);
    end
    n_tests++;
    if (ob_vec !== 3'(nsw - 1)) begin
      n_fail++;
      $display("FAIL final_vec s=%0d m=%0d: got %0d want %0d", s, m, ob_vec, nsw - 1);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; mode = 3'd0; tt = 8'h00; sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({a_vec, a_busy, a_done, a_pass, a_err, a_fev, a_fval,
         b_vec, b_busy, b_done, b_pass, b_err, b_fev, b_fval} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: a=%0h/%0b%0b%0b/%0h/%0h/%0b b=%0h/%0b%0b%0b/%0h/%0h/%0b want all 0",
               a_vec, a_busy, a_done, a_pass, a_err, a_fev, a_fval,
               b_vec, b_busy, b_done, b_pass, b_err, b_fev, b_fval);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed;
    tt = 8'b0000_0001;            // ideal 2-input NOR
    run_sweep(0, 3'd3, 0);
    run_sweep(0, 3'd0, 0);        // AND against NOR: misses at 00 and 11
    tt = 8'h00;                   // stuck-at-0
    run_sweep(1, 3'd1, 0);
  endtask

  task automatic test_mid_run_disturb;
    tt = 8'($urandom);
    run_sweep(1, 3'd1, 1);
    tt = 8'b0000_0001;
    run_sweep(0, 3'd0, 1);
  endtask

  task automatic test_reset_mid_run;
    tt = 8'($urandom);
    mode = 3'd1;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;                   // third RUN cycle
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++;
    if ({b_vec, b_busy, b_done, b_pass, b_err, b_fev, b_fval} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_run: vec=%0h busy=%0b done=%0b pass=%0b err=%0d fev=%0h fval=%0b want all 0",
               b_vec, b_busy, b_done, b_pass, b_err, b_fev, b_fval);
    end
    run_sweep(1, 3'd1, 0);
  endtask

  task automatic test_reserved(input int s, input logic [2:0] m, input bit chk_vec0);
    sel = (s != 0);
    mode = m;
    set_start(s, 1'b1);
    @(posedge clk); #1;
    set_start(s, 1'b0);
    for (int c = 0; c < 2; c++) begin
      n_tests++;
      if ({ob_done, ob_busy, ob_pass, ob_err} !== {3'b100, 4'd0} || (chk_vec0 && ob_vec !== 3'd0)) begin
        n_fail++;
        $display("FAIL reserved_mode s=%0d m=%0d c=%0d: done/busy/pass/err/vec got %0b/%0b/%0b/%0d/%0d want 1/0/0/0/0",
                 s, m, c, ob_done, ob_busy, ob_pass, ob_err, ob_vec);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 12; i++) begin
      int s = int'($urandom_range(0, 1));
      logic [2:0] m = 3'($urandom_range(0, 5));
      tt = 8'($urandom);
      if ($urandom_range(0, 2) == 0)
        for (int v = 0; v < 8; v++) tt[v] = ref_f(m, v, (s != 0) ? 3 : 2);
      run_sweep(s, m, 0);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_mid_run_disturb;
    test_reset_mid_run;
    tt = 8'($urandom);
    test_reserved(0, 3'd6, 1);    // A is idle after the mid-run reset
    run_sweep(0, 3'd5, 0);
    test_reserved(1, 3'd7, 0);    // from DONE
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/logic_sweep_checker.md
Name: logic_sweep_checker

Overview:
- Parametrised, self-contained truth-table sweeper and checker for N-input combinational logic gates.
- Drives every input combination 0..2^N_IN-1 onto the gate under test and samples its output after a programmable settle time.
- Compares each sample with the expected value for the selected gate function, then reports an error count, the first failing vector and an overall pass flag.
- Sits beside gate-level blocks as a reusable on-chip/bench checker; generalises single-gate, fixed-vector checking to N inputs and six gate functions.

Parameters:
- N_IN, 2, number of gate inputs (1..16); sweep covers 2^N_IN vectors.
- SETTLE, 1, cycles each vector is held before the gate output is sampled (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a sweep; sampled in IDLE and DONE only.
- mode  input  3  gate function; latched on accepted start. 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6-7 reserved.
- vec_out  output  N_IN  registered input vector driven to the gate under test.
- dut_y  input  1  output of the gate under test.
- busy  output  1  high while in RUN.
- done  output  1  high in DONE; sticky until the next accepted start or rst.
- pass  output  1  valid when done=1; high iff err_count==0 and mode was legal.
- err_count  output  N_IN+1  number of mismatching vectors; cannot overflow (maximum 2^N_IN).
- first_err_vec  output  N_IN  vector of the first mismatch in the current sweep.
- first_err_valid  output  1  high once a mismatch has been captured in the current sweep.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high; it dominates every other input.
- Reset values: state=IDLE, vec_out=0, busy=0, done=0, pass=0, err_count=0, first_err_vec=0, first_err_valid=0, hold counter=0.
- All outputs are registered.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1, legal mode:
  - latch mode; clear err_count, first_err_valid and first_err_vec.
  - vec_out<=0, hold counter<=0, go to RUN. busy rises on the next cycle.
- IDLE or DONE, start=1, reserved mode: go directly to DONE with pass=0 and err_count=0. No vectors are driven.
- RUN:
  - vec_out is held for exactly SETTLE cycles. The hold counter counts 0..SETTLE-1.
  - On the edge where the counter equals SETTLE-1, dut_y is compared with expected(mode, vec_out).
  - expected: AND = &vec, OR = |vec, NAND = ~&vec, NOR = ~|vec, XOR = ^vec, XNOR = ~^vec.
  - On a mismatch, err_count increments. If first_err_valid=0, capture first_err_vec<=vec_out and set first_err_valid.
  - After a sample, if vec_out is all ones, go to DONE. Otherwise vec_out<=vec_out+1 and the counter resets to 0.
  - start is ignored in RUN. mode changes after acceptance have no effect.
- DONE:
  - done=1, busy=0.
  - pass<=(err_count==0) accounts for the final sample's compare result in the same update.
  - vec_out holds its last value.
  - start=1 restarts as from IDLE, with counters cleared in the same edge; done falls on the next cycle.
- Latency: from start accepted (edge E), the sweep occupies 2^N_IN*SETTLE cycles in RUN. done is observed high 2^N_IN*SETTLE+1 cycles after E.
- Reset during RUN: the sweep is abandoned immediately, all outputs return to reset values, and there is no partial done.
- The gate under test is purely combinational; SETTLE covers any external registering.

Optional Feature:
- Macro SWEEP_STOP_ON_ERR_EN.
- Defined: on the first mismatch the FSM goes straight to DONE after that sample, with err_count=1, pass=0, first_err_vec = the failing vector, and vec_out held at that vector.
- Undefined: the full sweep always completes and err_count totals all mismatches.

Test Plan:
- N_IN=2, SETTLE=1, ideal NOR model, mode=3, pulse start -> vec_out steps 00,01,10,11 on consecutive cycles; done=1 exactly 5 cycles after the start edge; pass=1, err_count=0, first_err_valid=0.
- Same setup, mode=0 (AND) against the NOR model -> mismatches at 00 and 11; err_count=2, first_err_vec=00, first_err_valid=1, pass=0. With SWEEP_STOP_ON_ERR_EN defined: done after the first sample, err_count=1, vec_out=00.
- N_IN=3, SETTLE=3, dut_y stuck at 0, mode=1 (OR) -> each vector held 3 cycles; done 25 cycles after start; err_count=7, first_err_vec=001, pass=0.
- Start pulsed again mid-RUN, and mode changed to 4 mid-RUN -> no effect; the sweep completes with the original mode and result.
- rst asserted on the 3rd RUN cycle -> the next cycle shows all reset values; a subsequent start runs a clean full sweep with correct counts.
- mode=6 with start in IDLE -> DONE on the next cycle with pass=0, err_count=0, and vec_out never leaves 0. A following start with mode=5 runs a normal XNOR sweep, and done drops for its duration.
